// File: rtl/pong_pkg.sv
// Shared types and constants for the pong datapath: game states, score and coordinate widths.
package pong_pkg;

  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned SCORE_MAX = 15;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } game_state_t;

  // Score increment that sticks at the 4-bit display limit.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame-count down timer for the SERVE and POINT holds; zero_c flags the tick that empties it.
module frame_timer
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               frame_tick_i,
  output logic               zero_c
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (frame_tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted on the last tick so the controller leaves the hold the cycle after it.
  assign zero_c = (cnt_q == '0) || (frame_tick_i && (cnt_q == TIMER_W'(1)));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over flow, goal detection and scoring.
// Define PONG_WIN_BY_TWO_EN to require a two-point lead (15 always wins).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned LEFT_GOAL    = 10,
  parameter int unsigned RIGHT_GOAL   = 630
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               score_clr,
  input  logic [COORD_W-1:0] ball_x_pos,
  output logic               round_rst,
  output logic               play_en,
  output logic               serve_left,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               game_over,
  output logic               winner_right
);

  game_state_t        state_q;
  logic               start_q;
  logic               round_rst_q, play_en_q, serve_left_q, game_over_q, winner_right_q;
  logic [SCORE_W-1:0] left_q, right_q;

  logic               start_edge_c, goal_l_c, goal_r_c, win_c, zero_c;
  logic               timer_load_c;
  logic [TIMER_W-1:0] timer_val_c;
  logic [SCORE_W-1:0] scorer_c;

  assign start_edge_c = start && !start_q;
  assign goal_l_c     = ball_x_pos < COORD_W'(LEFT_GOAL);
  assign goal_r_c     = !goal_l_c && (ball_x_pos > COORD_W'(RIGHT_GOAL));

  // serve_left was set by the last goal, so it names the player who just scored.
  assign scorer_c = serve_left_q ? right_q : left_q;

`ifdef PONG_WIN_BY_TWO_EN
  logic [SCORE_W-1:0] other_c;
  assign other_c = serve_left_q ? left_q : right_q;
  assign win_c   = (scorer_c == SCORE_W'(SCORE_MAX)) ||
                   ((scorer_c >= SCORE_W'(WIN_SCORE)) &&
                    ({1'b0, scorer_c} >= ({1'b0, other_c} + (SCORE_W+1)'(2))));
`else
  assign win_c = scorer_c >= SCORE_W'(WIN_SCORE);
`endif

  always_comb begin
    timer_load_c = 1'b0;
    timer_val_c  = TIMER_W'(SERVE_FRAMES);
    if (score_clr) begin
      timer_load_c = 1'b1;
      timer_val_c  = '0;
    end else begin
      case (state_q)
        IDLE, GAME_OVER: timer_load_c = start_edge_c;
        PLAY: begin
          timer_load_c = goal_l_c || goal_r_c;
          timer_val_c  = TIMER_W'(POINT_FRAMES);
        end
        POINT:   timer_load_c = zero_c && !win_c;
        default: timer_load_c = 1'b0;
      endcase
    end
  end

  frame_timer u_frame_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load_c),
    .load_val_i   (timer_val_c),
    .frame_tick_i (frame_tick),
    .zero_c       (zero_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      round_rst_q    <= 1'b1;
      play_en_q      <= 1'b0;
      serve_left_q   <= 1'b0;
      left_q         <= '0;
      right_q        <= '0;
      game_over_q    <= 1'b0;
      winner_right_q <= 1'b0;
    end else begin
      start_q <= start;
      if (score_clr) begin
        state_q        <= IDLE;
        round_rst_q    <= 1'b1;
        play_en_q      <= 1'b0;
        serve_left_q   <= 1'b0;
        left_q         <= '0;
        right_q        <= '0;
        game_over_q    <= 1'b0;
        winner_right_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, GAME_OVER: begin
            if (start_edge_c) begin
              state_q      <= SERVE;
              round_rst_q  <= 1'b1;
              play_en_q    <= 1'b0;
              serve_left_q <= 1'b0;
              left_q       <= '0;
              right_q      <= '0;
              game_over_q  <= 1'b0;
            end
          end
          SERVE: begin
            if (zero_c) begin
              state_q     <= PLAY;
              round_rst_q <= 1'b0;
              play_en_q   <= 1'b1;
            end
          end
          PLAY: begin
            if (goal_l_c) begin
              state_q      <= POINT;
              play_en_q    <= 1'b0;
              right_q      <= sat_inc(right_q);
              serve_left_q <= 1'b1;
            end else if (goal_r_c) begin
              state_q      <= POINT;
              play_en_q    <= 1'b0;
              left_q       <= sat_inc(left_q);
              serve_left_q <= 1'b0;
            end
          end
          POINT: begin
            if (zero_c) begin
              round_rst_q <= 1'b1;
              if (win_c) begin
                state_q        <= GAME_OVER;
                game_over_q    <= 1'b1;
                winner_right_q <= serve_left_q;
              end else begin
                state_q <= SERVE;
              end
            end
          end
          default: begin
            state_q     <= IDLE;
            round_rst_q <= 1'b1;
            play_en_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign round_rst    = round_rst_q;
  assign play_en      = play_en_q;
  assign serve_left   = serve_left_q;
  assign left_score   = left_q;
  assign right_score  = right_q;
  assign game_over    = game_over_q;
  assign winner_right = winner_right_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: vector table for the basic flow plus hand-written match sequences.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int unsigned SERVE_F = 3;
  localparam int unsigned POINT_F = 2;

  logic               clk = 1'b0;
  logic               reset, frame_tick, start, score_clr;
  logic [COORD_W-1:0] ball_x_pos;
  logic               round_rst, play_en, serve_left, game_over, winner_right;
  logic [SCORE_W-1:0] left_score, right_score;
  logic [11:0]        obs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic               st;
    logic               clr;
    logic               tick;
    logic [COORD_W-1:0] x;
    logic [11:0]        exp;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .SERVE_FRAMES (SERVE_F),
    .POINT_FRAMES (POINT_F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .score_clr    (score_clr),
    .ball_x_pos   (ball_x_pos),
    .round_rst    (round_rst),
    .play_en      (play_en),
    .serve_left   (serve_left),
    .left_score   (left_score),
    .right_score  (right_score),
    .game_over    (game_over),
    .winner_right (winner_right)
  );

  assign obs = {round_rst, play_en, serve_left, left_score, right_score, game_over};

  function automatic logic [11:0] ex(input logic rr, input logic pe, input logic sl,
                                     input int l, input int r, input logic go);
    return {rr, pe, sl, 4'(l), 4'(r), go};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic new_match();
    score_clr = 1'b1;
    step();
    score_clr = 1'b0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    step();
  endtask

  task automatic serve_to_play();
    repeat (SERVE_F) tick();
    chk("serve_released", {31'd0, play_en}, 32'd1);
  endtask

  task automatic rally(input logic right_scores);
    serve_to_play();
    ball_x_pos = right_scores ? COORD_W'(5) : COORD_W'(635);
    step();
    ball_x_pos = COORD_W'(320);
    repeat (POINT_F) tick();
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    start      = 1'b0;
    score_clr  = 1'b0;
    ball_x_pos = COORD_W'(320);
    step();
    reset = 1'b0;
    chk("reset_state", {19'd0, obs, winner_right}, {19'd0, ex(1, 0, 0, 0, 0, 0), 1'b0});

    // {start, clr, tick, x, expected outputs after the edge}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'd320, ex(1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 10'd320, ex(1, 0, 0, 0, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 10'd320, ex(1, 0, 0, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'd320, ex(1, 0, 0, 0, 0, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 10'd320, ex(0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 10'd320, ex(0, 1, 0, 0, 0, 0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 10'd5,   ex(0, 0, 1, 0, 1, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 10'd5,   ex(0, 0, 1, 0, 1, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'd320, ex(1, 0, 1, 0, 1, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 10'd320, ex(1, 0, 1, 0, 1, 0)};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10'd9,   ex(1, 0, 1, 0, 1, 0)};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 10'd320, ex(0, 1, 1, 0, 1, 0)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 10'd635, ex(0, 0, 0, 1, 1, 0)};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 10'd320, ex(0, 0, 0, 1, 1, 0)};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 10'd320, ex(1, 0, 0, 1, 1, 0)};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 10'd320, ex(1, 0, 0, 1, 1, 0)};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 10'd630, ex(1, 0, 0, 1, 1, 0)};

    for (int i = 0; i < 17; i++) begin
      start      = vecs[i].st;
      score_clr  = vecs[i].clr;
      frame_tick = vecs[i].tick;
      ball_x_pos = vecs[i].x;
      step();
      chk($sformatf("vec%0d", i), {20'd0, obs}, {20'd0, vecs[i].exp});
    end
    start      = 1'b0;
    frame_tick = 1'b0;
    ball_x_pos = COORD_W'(320);

    // Goal boundaries: x=10 and x=630 are not goals.
    new_match();
    serve_to_play();
    ball_x_pos = COORD_W'(10);
    step();
    ball_x_pos = COORD_W'(630);
    step();
    chk("goal_edges", {20'd0, obs}, {20'd0, ex(0, 1, 0, 0, 0, 0)});
    ball_x_pos = COORD_W'(631);
    step();
    ball_x_pos = COORD_W'(320);
    chk("goal_631", {20'd0, obs}, {20'd0, ex(0, 0, 0, 1, 0, 0)});
    repeat (POINT_F) tick();

    // Async reset mid-PLAY at 3-2.
    new_match();
    rally(1'b0); rally(1'b0); rally(1'b0); rally(1'b1); rally(1'b1);
    serve_to_play();
    chk("pre_reset_play", {20'd0, obs}, {20'd0, ex(0, 1, 1, 3, 2, 0)});
    reset = 1'b1;
    #2;
    chk("async_reset", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 0)});
    step();
    reset = 1'b0;
    step();

    // Left player wins.
    new_match();
`ifdef PONG_WIN_BY_TWO_EN
    repeat (8) rally(1'b1);
    repeat (9) rally(1'b0);
    chk("win_9_8_serve", {20'd0, obs}, {20'd0, ex(1, 0, 0, 9, 8, 0)});
    rally(1'b0);
    chk("win_10_8", {19'd0, obs, winner_right}, {19'd0, ex(1, 0, 0, 10, 8, 1), 1'b0});
`else
    repeat (7) rally(1'b1);
    repeat (8) rally(1'b0);
    chk("score_8_7_serve", {20'd0, obs}, {20'd0, ex(1, 0, 0, 8, 7, 0)});
    rally(1'b0);
    chk("win_9_7", {19'd0, obs, winner_right}, {19'd0, ex(1, 0, 0, 9, 7, 1), 1'b0});
`endif
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("game_over_hold", {31'd0, game_over}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_from_go", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 0)});
    step();
    serve_to_play();

`ifdef PONG_WIN_BY_TWO_EN
    // Deuce to 14-14, then 15 wins on the cap.
    new_match();
    for (int i = 0; i < 14; i++) begin
      rally(1'b0);
      rally(1'b1);
    end
    chk("deuce_14_14", {20'd0, obs}, {20'd0, ex(1, 0, 1, 14, 14, 0)});
    rally(1'b1);
    chk("cap_15_14", {19'd0, obs, winner_right}, {19'd0, ex(1, 0, 1, 14, 15, 1), 1'b1});
`endif

    // score_clr coincident with a goal discards the goal.
    new_match();
    rally(1'b0);
    serve_to_play();
    chk("pre_clr", {20'd0, obs}, {20'd0, ex(0, 1, 0, 1, 0, 0)});
    ball_x_pos = COORD_W'(635);
    score_clr  = 1'b1;
    step();
    score_clr  = 1'b0;
    ball_x_pos = COORD_W'(320);
    chk("clr_vs_goal", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 0)});
    repeat (4) tick();
    chk("idle_ignores_tick", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 0)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
